// File: rtl/sensor_ctrl_if.sv
// sensor_ctrl_if: bundles the slave-wrapper control/read signals and the
// sensor handshake used by sensor_ctrl.
//   slave  modport : the view taken by sensor_ctrl itself
//   master modport : the view taken by the AHB slave wrapper / sensor side
// Signals:
//   sctrl_en, sctrl_clear, sctrl_addr     control and read address from the wrapper
//   sctrl_out, sctrl_interrupt            read data and buffer-full flag to the wrapper
//   sensor_en                             sample request to the sensor
//   sensor_ready, sensor_out              sample strobe and data from the sensor
//   sctrl_count                           valid-sample count (only with SCTRL_SAMPLE_CNT_EN)
interface sensor_ctrl_if #(
  parameter int unsigned ADDRWIDTH = 6,
  parameter int unsigned DATAWIDTH = 32
);
  logic                 sctrl_en;
  logic                 sctrl_clear;
  logic [ADDRWIDTH-1:0] sctrl_addr;
  logic [DATAWIDTH-1:0] sctrl_out;
  logic                 sctrl_interrupt;
  logic                 sensor_en;
  logic                 sensor_ready;
  logic [DATAWIDTH-1:0] sensor_out;
`ifdef SCTRL_SAMPLE_CNT_EN
  logic [ADDRWIDTH:0]   sctrl_count;
`endif

  modport slave (
    input  sctrl_en, sctrl_clear, sctrl_addr, sensor_ready, sensor_out,
    output sctrl_out, sctrl_interrupt, sensor_en
`ifdef SCTRL_SAMPLE_CNT_EN
    , output sctrl_count
`endif
  );

  modport master (
    output sctrl_en, sctrl_clear, sctrl_addr, sensor_ready, sensor_out,
    input  sctrl_out, sctrl_interrupt, sensor_en
`ifdef SCTRL_SAMPLE_CNT_EN
    , input sctrl_count
`endif
  );
endinterface

// File: rtl/sensor_ctrl.sv
// sensor_ctrl: sequences the external sensor and buffers its samples in a
// DEPTH-word (2**ADDRWIDTH) buffer read by the AHB sensor slave wrapper.
// While enabled, sensor_en requests samples; each sensor_ready pulse stores
// sensor_out at the write pointer. When the buffer fills, sensor_en drops and
// sctrl_interrupt rises until sctrl_clear, which rewinds the pointer without
// erasing the buffer.
// Ports:
//   HCLK     clock, rising edge
//   HRESETn  asynchronous active-low reset
//   bus      sensor_ctrl_if.slave (control, read port, sensor handshake)
// Configuration:
//   SCTRL_SAMPLE_CNT_EN  when defined, drives bus.sctrl_count with the write
//                        pointer (number of valid samples).
module sensor_ctrl #(
  parameter int unsigned ADDRWIDTH = 6,
  parameter int unsigned DATAWIDTH = 32
) (
  input logic          HCLK,
  input logic          HRESETn,
  sensor_ctrl_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDRWIDTH;
  localparam logic [ADDRWIDTH:0] LAST_IDX = (ADDRWIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDRWIDTH:0] PTR_ONE  = (ADDRWIDTH + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FULL
  } state_t;

  state_t               state;
  logic [ADDRWIDTH:0]   wptr;
  logic                 sensor_en_q;
  logic                 int_q;
  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic                 wr_en;

  // Clear has priority: a sample arriving in the clear cycle is dropped.
  assign wr_en = (state == REQ) && bus.sensor_ready && !bus.sctrl_clear;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= IDLE;
      wptr        <= '0;
      sensor_en_q <= 1'b0;
      int_q       <= 1'b0;
    end else if (bus.sctrl_clear) begin
      state       <= IDLE;
      wptr        <= '0;
      sensor_en_q <= 1'b0;
      int_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.sctrl_en) begin
            state       <= REQ;
            sensor_en_q <= 1'b1;
          end
        end
        REQ: begin
          if (bus.sensor_ready) begin
            wptr <= wptr + PTR_ONE;
          end
          // Filling the last word wins over a same-cycle disable.
          if (bus.sensor_ready && (wptr == LAST_IDX)) begin
            state       <= FULL;
            sensor_en_q <= 1'b0;
            int_q       <= 1'b1;
          end else if (!bus.sctrl_en) begin
            state       <= IDLE;
            sensor_en_q <= 1'b0;
          end
        end
        FULL: begin
          state <= FULL;
        end
        default: begin
          state       <= IDLE;
          sensor_en_q <= 1'b0;
          int_q       <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wptr[ADDRWIDTH-1:0]] <= bus.sensor_out;
    end
  end

  assign bus.sctrl_out       = mem[bus.sctrl_addr];
  assign bus.sensor_en       = sensor_en_q;
  assign bus.sctrl_interrupt = int_q;
`ifdef SCTRL_SAMPLE_CNT_EN
  assign bus.sctrl_count     = wptr;
`endif

endmodule

// File: tb/tb_sensor_ctrl.sv
// tb_sensor_ctrl: self-checking bench for sensor_ctrl with a behavioural
// buffer/acquisition model and randomized stimulus.
module tb_sensor_ctrl;

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;

  logic HCLK;
  logic HRESETn;
  int   checks   = 0;
  int   failures = 0;

  sensor_ctrl_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) bus ();

  sensor_ctrl #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.slave)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Behavioural model: buffer contents, number of stored samples, and
  // whether the block is currently acquiring or holding a full buffer.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_cnt;
  bit            m_active;
  bit            m_full;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
      m_cnt    <= 0;
      m_active <= 1'b0;
      m_full   <= 1'b0;
    end else if (bus.sctrl_clear) begin
      m_cnt    <= 0;
      m_active <= 1'b0;
      m_full   <= 1'b0;
    end else if (m_full) begin
      m_full <= 1'b1;
    end else if (m_active) begin
      if (bus.sensor_ready) begin
        m_mem[m_cnt] <= bus.sensor_out;
        m_cnt        <= m_cnt + 1;
      end
      if (bus.sensor_ready && (m_cnt + 1 == DEPTH)) begin
        m_full   <= 1'b1;
        m_active <= 1'b0;
      end else if (!bus.sctrl_en) begin
        m_active <= 1'b0;
      end
    end else if (bus.sctrl_en) begin
      m_active <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge HCLK) begin
    if (HRESETn) begin
      check("sensor_en", 64'(bus.sensor_en), 64'(m_active));
      check("sctrl_interrupt", 64'(bus.sctrl_interrupt), 64'(m_full));
      check("sctrl_out", 64'(bus.sctrl_out), 64'(m_mem[bus.sctrl_addr]));
`ifdef SCTRL_SAMPLE_CNT_EN
      check("sctrl_count", 64'(bus.sctrl_count), 64'(m_cnt));
`endif
    end
  end

  task automatic pulse(input logic [DW-1:0] d);
    @(posedge HCLK); #1;
    bus.sensor_ready = 1'b1;
    bus.sensor_out   = d;
    @(posedge HCLK); #1;
    bus.sensor_ready = 1'b0;
  endtask

  task automatic read_chk(input string name, input int addr, input logic [DW-1:0] exp);
    bus.sctrl_addr = AW'(addr);
    #1;
    check(name, 64'(bus.sctrl_out), 64'(exp));
  endtask

  initial begin
    HRESETn          = 1'b0;
    bus.sctrl_en     = 1'b0;
    bus.sctrl_clear  = 1'b0;
    bus.sctrl_addr   = '0;
    bus.sensor_ready = 1'b0;
    bus.sensor_out   = '0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    check("reset_sensor_en", 64'(bus.sensor_en), 64'd0);
    check("reset_interrupt", 64'(bus.sctrl_interrupt), 64'd0);

    // Reset in the middle of acquisition at wptr=10.
    bus.sctrl_en = 1'b1;
    repeat (10) pulse($urandom);
    check("pre_reset_sensor_en", 64'(bus.sensor_en), 64'd1);
    @(posedge HCLK); #3;
    HRESETn = 1'b0;
    #1;
    check("async_reset_sensor_en", 64'(bus.sensor_en), 64'd0);
    check("async_reset_interrupt", 64'(bus.sctrl_interrupt), 64'd0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn      = 1'b1;
    bus.sctrl_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) read_chk("reset_mem", i, '0);

    // Fill the buffer.
    @(posedge HCLK); #1;
    bus.sctrl_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) pulse(DW'(32'h100 + i));
    check("full_interrupt", 64'(bus.sctrl_interrupt), 64'd1);
    check("full_sensor_en", 64'(bus.sensor_en), 64'd0);
    pulse(32'hDEAD_BEEF);
    read_chk("full_mem0", 0, 32'h100);
    read_chk("full_mem63", 63, 32'h13F);
    read_chk("full_mem5", 5, 32'h105);

    // Clear from FULL, restart at address 0.
    @(posedge HCLK); #1;
    bus.sctrl_clear = 1'b1;
    @(posedge HCLK); #1;
    bus.sctrl_clear = 1'b0;
    check("clear_interrupt", 64'(bus.sctrl_interrupt), 64'd0);
    @(posedge HCLK); #1;
    check("clear_resume_sensor_en", 64'(bus.sensor_en), 64'd1);
    pulse(32'h0000_AAAA);
    read_chk("clear_mem0", 0, 32'h0000_AAAA);
    read_chk("clear_mem1_kept", 1, 32'h101);

    // Clear and sample in the same cycle at wptr=5.
    for (int i = 0; i < 4; i++) pulse(DW'(32'h1000 + i));
    @(posedge HCLK); #1;
    bus.sctrl_clear  = 1'b1;
    bus.sensor_ready = 1'b1;
    bus.sensor_out   = 32'h0000_0BAD;
    @(posedge HCLK); #1;
    bus.sctrl_clear  = 1'b0;
    bus.sensor_ready = 1'b0;
    read_chk("clr_rdy_mem5", 5, 32'h105);
    read_chk("clr_rdy_mem4", 4, 32'h1003);
`ifdef SCTRL_SAMPLE_CNT_EN
    check("clr_rdy_count", 64'(bus.sctrl_count), 64'd0);
`endif

    // Disable after 20 samples, pulses while disabled, then resume.
    for (int i = 0; i < 20; i++) pulse(DW'(32'h200 + i));
    bus.sctrl_en = 1'b0;
    for (int i = 0; i < 3; i++) pulse(DW'(32'hEEEE_0000 + i));
    bus.sctrl_en = 1'b1;
    pulse(32'h0000_5555);
    read_chk("resume_mem20", 20, 32'h0000_5555);
    read_chk("resume_mem21", 21, 32'h115);
    read_chk("resume_mem19", 19, 32'h213);

    // Read-during-write at address 3.
    @(posedge HCLK); #1;
    bus.sctrl_clear = 1'b1;
    @(posedge HCLK); #1;
    bus.sctrl_clear = 1'b0;
    bus.sctrl_addr  = AW'(3);
    for (int i = 0; i < 4; i++) begin
      @(posedge HCLK); #1;
      bus.sensor_ready = 1'b1;
      bus.sensor_out   = DW'(32'h300 + i);
      if (i == 3) begin
        #1 check("rdw_old", 64'(bus.sctrl_out), 64'h203);
      end
      @(posedge HCLK); #1;
      bus.sensor_ready = 1'b0;
      if (i == 3) check("rdw_new", 64'(bus.sctrl_out), 64'h303);
    end

    // Randomized traffic; clears are rare except while the buffer is full.
    for (int n = 0; n < 3000; n++) begin
      @(posedge HCLK); #1;
      bus.sctrl_en     = ($urandom_range(0, 9) != 0);
      bus.sensor_ready = $urandom_range(0, 1) == 1;
      bus.sensor_out   = $urandom;
      bus.sctrl_addr   = AW'($urandom);
      bus.sctrl_clear  = m_full ? ($urandom_range(0, 7) == 0)
                                : ($urandom_range(0, 299) == 0);
    end

    @(posedge HCLK); #1;
    bus.sensor_ready = 1'b0;
    bus.sctrl_clear  = 1'b0;
    bus.sctrl_en     = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
